branch_predict_unit: RTL and testbench

// - EX-stage branch resolution with 2-bit dynamic prediction: resolves all six RV32I B-type conditions, JAL, JALR and halt.
// - A branch history table (BHT) gives fetch a taken/not-taken hint; EX detects mispredicts and drives the PC redirect.
// - Sits between the IF PC mux and the EX stage and replaces the always-not-taken branch logic.

---
 rtl/branch_predict_unit.sv | 223 ++++++++++++++++++++++
 tb/tb_branch_predict_unit.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// -----------------------------------------------------------------------------
// branch_predict_unit
//   EX-stage branch resolution with a 2-bit saturating-counter branch history
//   table (BHT). Resolves the six RV32I B-type conditions, JAL, JALR and halt,
//   gives fetch a taken/not-taken hint, and drives the PC redirect and flush.
//
//   Optional feature (compile-time macro BRU_PERF_CNT_EN):
//     adds perf_branches / perf_mispredicts event counters and their ports.
//
//   Reset is synchronous and active-low on the port named 'reset'.
// -----------------------------------------------------------------------------
module branch_predict_unit #(
   parameter int PC_W       = 9,
   parameter int DATA_WIDTH = 32,
   parameter int BHT_IDX_W  = 4,
   parameter int CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   // fetch-side lookup
   input  logic [PC_W-1:0]       if_pc,
   output logic                  pred_taken,
   // EX-stage instruction
   input  logic                  ex_valid,
   input  logic [PC_W-1:0]       ex_pc,
   input  logic [31:0]           ex_imm,
   input  logic [2:0]            ex_funct3,
   input  logic                  ex_branch,
   input  logic                  ex_jal,
   input  logic                  ex_jalr,
   input  logic                  ex_halt,
   input  logic                  ex_pred_taken,
   input  logic [DATA_WIDTH-1:0] src_a,
   input  logic [DATA_WIDTH-1:0] src_b,
   // targets and redirect
   output logic [31:0]           pc_imm,
   output logic [31:0]           pc_four,
   output logic [31:0]           br_pc,
   output logic                  pc_sel,
   output logic                  is_jal,
   output logic                  mispredict,
   output logic                  halted
`ifdef BRU_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]      perf_branches,
   output logic [CNT_W-1:0]      perf_mispredicts
`endif
);

   localparam int BHT_ENTRIES = 1 << BHT_IDX_W;

   // 2-bit counter encodings
   localparam logic [1:0] CNT_SNT = 2'b00;
   localparam logic [1:0] CNT_WNT = 2'b01;
   localparam logic [1:0] CNT_ST  = 2'b11;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } state_t;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t            state_q, state_d;
   logic [PC_W-1:0]   halt_pc_q, halt_pc_d;
   logic [1:0]        bht_q [BHT_ENTRIES];
   logic [1:0]        bht_d [BHT_ENTRIES];

   // ---------------------------------------------------------------------------
   // Datapath helpers
   // ---------------------------------------------------------------------------
   logic [31:0]          pc_ext;
   logic [31:0]          src_a_32;
   logic [BHT_IDX_W-1:0] if_idx;
   logic [BHT_IDX_W-1:0] ex_idx;
   logic [1:0]           ex_cnt;
   logic                 act_t;
   logic                 f3_valid;
   logic                 bht_upd;
   logic                 br_mis;
   logic                 idx_unused;

   assign pc_ext   = {{(32-PC_W){1'b0}}, ex_pc};
   assign src_a_32 = 32'(src_a);
   assign if_idx   = if_pc[BHT_IDX_W+1:2];
   assign ex_idx   = ex_pc[BHT_IDX_W+1:2];
   assign ex_cnt   = bht_q[ex_idx];

   // if_pc bits outside the index field do not take part in the lookup
   assign idx_unused = ^{if_pc[PC_W-1:BHT_IDX_W+2], if_pc[1:0]};

   // Fetch hint: MSB of the counter, read before any same-cycle update lands.
   assign pred_taken = bht_q[if_idx][1];

   // Targets; all arithmetic wraps modulo 2^32.
   assign pc_four = pc_ext + 32'd4;
   assign pc_imm  = ex_jalr ? ((src_a_32 + ex_imm) & ~32'h1) : (pc_ext + ex_imm);

   // Branch condition evaluation; funct3 010/011 are reserved and never taken.
   always_comb begin
      // NOTE: every variable written here gets a default first, otherwise a
      // path that skips the assignment would infer a latch.
      act_t    = 1'b0;
      f3_valid = 1'b1;
      case (ex_funct3)
         3'b000:  act_t = (src_a == src_b);
         3'b001:  act_t = (src_a != src_b);
         3'b100:  act_t = ($signed(src_a) <  $signed(src_b));
         3'b101:  act_t = ($signed(src_a) >= $signed(src_b));
         3'b110:  act_t = (src_a <  src_b);
         3'b111:  act_t = (src_a >= src_b);
         default: f3_valid = 1'b0;
      endcase
   end

   // Redirect outputs, FSM next state and BHT next state.
   always_comb begin
      state_d    = state_q;
      halt_pc_d  = halt_pc_q;
      for (int i = 0; i < BHT_ENTRIES; i++) begin
         bht_d[i] = bht_q[i];
      end
      pc_sel     = 1'b0;
      br_pc      = 32'h0;
      mispredict = 1'b0;
      is_jal     = 1'b0;
      halted     = 1'b0;
      bht_upd    = 1'b0;
      br_mis     = 1'b0;

      if (!reset) begin
         // outputs stay at their zero defaults while reset is held
      end else if (state_q == ST_HALTED) begin
         // parked: keep steering fetch to the halt PC
         pc_sel = 1'b1;
         br_pc  = {{(32-PC_W){1'b0}}, halt_pc_q};
         halted = 1'b1;
      end else if (ex_valid && ex_halt) begin
         // halt wins over any jump/branch bits on the same instruction
         state_d   = ST_HALTED;
         halt_pc_d = ex_pc;
         pc_sel    = 1'b1;
         br_pc     = pc_ext;
         halted    = 1'b1;
      end else if (ex_valid) begin
         is_jal = ex_jal || ex_jalr;
         if (ex_jal || ex_jalr) begin
            // jumps are never predicted, so they always redirect
            pc_sel     = 1'b1;
            br_pc      = pc_imm;
            mispredict = 1'b1;
         end else if (ex_branch && (act_t != ex_pred_taken)) begin
            pc_sel     = 1'b1;
            mispredict = 1'b1;
            br_pc      = act_t ? pc_imm : pc_four;
            br_mis     = 1'b1;
         end

         if (ex_branch && f3_valid) begin
            bht_upd = 1'b1;
            if (act_t) begin
               bht_d[ex_idx] = (ex_cnt == CNT_ST) ? CNT_ST : ex_cnt + 2'b01;
            end else begin
               bht_d[ex_idx] = (ex_cnt == CNT_SNT) ? CNT_SNT : ex_cnt - 2'b01;
            end
         end
      end
   end

   // State register, halt PC latch and BHT storage.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value regardless of statement order.
      if (!reset) begin
         state_q   <= ST_RUN;
         halt_pc_q <= '0;
         // NOTE: the table is built from flops, not a RAM macro, so every
         // entry can be loaded with weak-not-taken in the reset cycle.
         for (int i = 0; i < BHT_ENTRIES; i++) begin
            bht_q[i] <= CNT_WNT;
         end
      end else begin
         state_q   <= state_d;
         halt_pc_q <= halt_pc_d;
         for (int i = 0; i < BHT_ENTRIES; i++) begin
            bht_q[i] <= bht_d[i];
         end
      end
   end

`ifdef BRU_PERF_CNT_EN
   logic [CNT_W-1:0] perf_br_q, perf_br_d;
   logic [CNT_W-1:0] perf_mis_q, perf_mis_d;

   // Event counters; they freeze in HALTED because no branch events occur there.
   always_comb begin
      perf_br_d  = perf_br_q  + CNT_W'(bht_upd);
      perf_mis_d = perf_mis_q + CNT_W'(br_mis);
   end

   // Counter registers, cleared by reset and wrapping on overflow.
   always_ff @(posedge clk) begin
      if (!reset) begin
         perf_br_q  <= '0;
         perf_mis_q <= '0;
      end else begin
         perf_br_q  <= perf_br_d;
         perf_mis_q <= perf_mis_d;
      end
   end

   assign perf_branches    = perf_br_q;
   assign perf_mispredicts = perf_mis_q;
`else
   // Counters are absent; tie off a sink so the width parameter stays referenced.
   logic [CNT_W-1:0] perf_unused;
   logic             br_event_unused;
   assign perf_unused     = '0;
   assign br_event_unused = bht_upd ^ br_mis;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_predict_unit
//   Self-checking bench for branch_predict_unit. A behavioural model (integer
//   counter array, halted flag, event counts) is evaluated after inputs settle
//   and committed at each rising edge. Inputs change on the falling edge and
//   outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_branch_predict_unit;

   localparam int PC_W       = 9;
   localparam int DATA_WIDTH = 32;
   localparam int BHT_IDX_W  = 4;
   localparam int CNT_W      = 32;
   localparam int N_ENT      = 16;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [PC_W-1:0]       if_pc;
   logic                  pred_taken;
   logic                  ex_valid;
   logic [PC_W-1:0]       ex_pc;
   logic [31:0]           ex_imm;
   logic [2:0]            ex_funct3;
   logic                  ex_branch, ex_jal, ex_jalr, ex_halt, ex_pred_taken;
   logic [DATA_WIDTH-1:0] src_a, src_b;
   logic [31:0]           pc_imm, pc_four, br_pc;
   logic                  pc_sel, is_jal, mispredict, halted;
`ifdef BRU_PERF_CNT_EN
   logic [CNT_W-1:0]      perf_branches, perf_mispredicts;
`endif

   int checks = 0;
   int errors = 0;

   // model state
   int          m_bht [N_ENT];
   bit          m_halted;
   logic [31:0] m_halt_pc;
   int          m_nbr, m_nmis;

   // model expectations for the current cycle
   logic [31:0] exp_pc_imm, exp_pc_four, exp_br_pc;
   logic        exp_pc_sel, exp_mis, exp_is_jal, exp_halted, exp_pred;

   branch_predict_unit #(
      .PC_W(PC_W), .DATA_WIDTH(DATA_WIDTH), .BHT_IDX_W(BHT_IDX_W), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset),
      .if_pc(if_pc), .pred_taken(pred_taken),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_funct3(ex_funct3),
      .ex_branch(ex_branch), .ex_jal(ex_jal), .ex_jalr(ex_jalr), .ex_halt(ex_halt),
      .ex_pred_taken(ex_pred_taken), .src_a(src_a), .src_b(src_b),
      .pc_imm(pc_imm), .pc_four(pc_four), .br_pc(br_pc), .pc_sel(pc_sel),
      .is_jal(is_jal), .mispredict(mispredict), .halted(halted)
`ifdef BRU_PERF_CNT_EN
      , .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
`endif
   );

   always #5 clk = ~clk;

   // ---------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------
   function automatic int idx_of(input logic [PC_W-1:0] pc);
      return (int'(pc) / 4) % N_ENT;
   endfunction

   function automatic bit cond_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      case (f3)
         3'd0:    return a == b;
         3'd1:    return a != b;
         3'd4:    return $signed(a) <  $signed(b);
         3'd5:    return $signed(a) >= $signed(b);
         3'd6:    return a <  b;
         3'd7:    return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   function automatic bit model_pred(input logic [PC_W-1:0] pc);
      return m_bht[idx_of(pc)] >= 2;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < N_ENT; i++) m_bht[i] = 1;
      m_halted  = 1'b0;
      m_halt_pc = 32'h0;
      m_nbr     = 0;
      m_nmis    = 0;
   endfunction

   function automatic void model_eval();
      logic [31:0] pcx;
      bit          t;
      pcx         = 32'(ex_pc);
      t           = cond_taken(ex_funct3, src_a, src_b);
      exp_pc_imm  = ex_jalr ? ((src_a + ex_imm) & 32'hFFFF_FFFE) : (pcx + ex_imm);
      exp_pc_four = pcx + 32'd4;
      exp_pred    = model_pred(if_pc);
      exp_pc_sel  = 1'b0;
      exp_br_pc   = 32'h0;
      exp_mis     = 1'b0;
      exp_is_jal  = 1'b0;
      exp_halted  = 1'b0;
      if (reset) begin
         if (m_halted) begin
            exp_pc_sel = 1'b1; exp_br_pc = m_halt_pc; exp_halted = 1'b1;
         end else if (ex_valid && ex_halt) begin
            exp_pc_sel = 1'b1; exp_br_pc = pcx; exp_halted = 1'b1;
         end else if (ex_valid) begin
            exp_is_jal = ex_jal | ex_jalr;
            if (ex_jal || ex_jalr) begin
               exp_pc_sel = 1'b1; exp_mis = 1'b1; exp_br_pc = exp_pc_imm;
            end else if (ex_branch && t != ex_pred_taken) begin
               exp_pc_sel = 1'b1; exp_mis = 1'b1;
               exp_br_pc  = t ? exp_pc_imm : exp_pc_four;
            end
         end
      end
   endfunction

   function automatic void model_commit();
      bit t;
      int i;
      t = cond_taken(ex_funct3, src_a, src_b);
      i = idx_of(ex_pc);
      if (!reset) begin
         model_reset();
      end else if (!m_halted) begin
         if (ex_valid && ex_halt) begin
            m_halted  = 1'b1;
            m_halt_pc = 32'(ex_pc);
         end else if (ex_valid) begin
            if (ex_branch && !ex_jal && !ex_jalr && t != ex_pred_taken) m_nmis++;
            if (ex_branch && ex_funct3 != 3'd2 && ex_funct3 != 3'd3) begin
               m_nbr++;
               m_bht[i] = t ? ((m_bht[i] == 3) ? 3 : m_bht[i] + 1)
                            : ((m_bht[i] == 0) ? 0 : m_bht[i] - 1);
            end
         end
      end
   endfunction

   // ---------------------------------------------------------------------------
   // Stimulus helpers
   // ---------------------------------------------------------------------------
   task automatic clear_inputs();
      if_pc = '0; ex_valid = 1'b0; ex_pc = '0; ex_imm = '0; ex_funct3 = '0;
      ex_branch = 1'b0; ex_jal = 1'b0; ex_jalr = 1'b0; ex_halt = 1'b0;
      ex_pred_taken = 1'b0; src_a = '0; src_b = '0;
   endtask

   task automatic begin_cycle();
      @(negedge clk);
      reset = 1'b1;
      clear_inputs();
   endtask

   task automatic settle();
      #1;
      model_eval();
   endtask

   task automatic commit();
      @(posedge clk);
      model_commit();
   endtask

   // ---------------------------------------------------------------------------
   // Tests
   // ---------------------------------------------------------------------------
   task automatic test_reset();
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         clear_inputs();
         reset = 1'b0; ex_valid = 1'b1; ex_jal = (c == 0); ex_halt = (c == 1);
         ex_branch = 1'b1; ex_pred_taken = 1'b1; src_a = 32'd1;
         settle();
         checks++; if (pc_sel !== 1'b0) begin errors++; $display("FAIL reset_pc_sel: got %b want 0", pc_sel); end
         checks++; if (br_pc !== 32'h0) begin errors++; $display("FAIL reset_br_pc: got %h want 0", br_pc); end
         checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL reset_mispredict: got %b want 0", mispredict); end
         checks++; if (is_jal !== 1'b0) begin errors++; $display("FAIL reset_is_jal: got %b want 0", is_jal); end
         checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
         commit();
      end
      // every entry starts weak-not-taken
      for (int i = 0; i < N_ENT; i++) begin
         begin_cycle();
         if_pc = PC_W'(i * 4);
         settle();
         checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_bht[%0d]: got %b want 0", i, pred_taken); end
         commit();
      end
   endtask

   task automatic test_beq_loop();
      // three taken iterations then two not-taken, prediction taken from the table
      logic       want_pred [5];
      logic       want_mis  [5];
      logic [31:0] want_br  [5];
      want_pred = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      want_mis  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      want_br   = '{32'h38, 32'h0, 32'h0, 32'h44, 32'h44};
      for (int k = 0; k < 5; k++) begin
         begin_cycle();
         if_pc = 9'h40; ex_valid = 1'b1; ex_pc = 9'h40; ex_imm = 32'hFFFF_FFF8;
         ex_funct3 = 3'b000; ex_branch = 1'b1;
         src_a = 32'd5; src_b = (k < 3) ? 32'd5 : 32'd6;
         ex_pred_taken = model_pred(ex_pc);
         settle();
         checks++; if (pred_taken !== want_pred[k]) begin errors++; $display("FAIL beq_pred[%0d]: got %b want %b", k, pred_taken, want_pred[k]); end
         checks++; if (mispredict !== want_mis[k]) begin errors++; $display("FAIL beq_mis[%0d]: got %b want %b", k, mispredict, want_mis[k]); end
         checks++; if (pc_sel !== want_mis[k]) begin errors++; $display("FAIL beq_pc_sel[%0d]: got %b want %b", k, pc_sel, want_mis[k]); end
         checks++; if (br_pc !== want_br[k]) begin errors++; $display("FAIL beq_br_pc[%0d]: got %h want %h", k, br_pc, want_br[k]); end
         checks++; if (pc_imm !== exp_pc_imm) begin errors++; $display("FAIL beq_pc_imm[%0d]: got %h want %h", k, pc_imm, exp_pc_imm); end
         commit();
      end
   endtask

   task automatic test_signed_unsigned();
      // BLT: -1 < 1 taken, predicted not taken -> redirect to target
      begin_cycle();
      ex_valid = 1'b1; ex_pc = 9'h10; ex_imm = 32'h20; ex_funct3 = 3'b100; ex_branch = 1'b1;
      src_a = 32'hFFFF_FFFF; src_b = 32'd1; ex_pred_taken = 1'b0;
      settle();
      checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL blt_mis: got %b want 1", mispredict); end
      checks++; if (br_pc !== 32'h30) begin errors++; $display("FAIL blt_br_pc: got %h want 30", br_pc); end
      commit();
      // BLTU: 0xFFFFFFFF < 1 false, predicted taken -> redirect to pc+4
      begin_cycle();
      ex_valid = 1'b1; ex_pc = 9'h10; ex_imm = 32'h20; ex_funct3 = 3'b110; ex_branch = 1'b1;
      src_a = 32'hFFFF_FFFF; src_b = 32'd1; ex_pred_taken = 1'b1;
      settle();
      checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL bltu_mis: got %b want 1", mispredict); end
      checks++; if (br_pc !== 32'h14) begin errors++; $display("FAIL bltu_br_pc: got %h want 14", br_pc); end
      checks++; if (pc_four !== 32'h14) begin errors++; $display("FAIL bltu_pc_four: got %h want 14", pc_four); end
      commit();
   endtask

   task automatic test_jalr();
      for (int k = 0; k < 2; k++) begin
         begin_cycle();
         ex_valid = 1'b1; ex_pc = 9'h20; ex_imm = 32'd4; ex_jalr = 1'b1;
         ex_funct3 = 3'b000; src_a = 32'h103; src_b = 32'h103; if_pc = 9'h20;
         settle();
         checks++; if (br_pc !== 32'h106) begin errors++; $display("FAIL jalr_br_pc: got %h want 106", br_pc); end
         checks++; if (pc_four !== 32'h24) begin errors++; $display("FAIL jalr_pc_four: got %h want 24", pc_four); end
         checks++; if (is_jal !== 1'b1) begin errors++; $display("FAIL jalr_is_jal: got %b want 1", is_jal); end
         checks++; if (mispredict !== 1'b1 || pc_sel !== 1'b1) begin errors++; $display("FAIL jalr_redirect: got mis=%b sel=%b want 1/1", mispredict, pc_sel); end
         commit();
      end
      // the entry must still read not-taken after two jumps with an equal-operand funct3
      begin_cycle();
      if_pc = 9'h20;
      settle();
      checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL jalr_no_bht: got %b want 0", pred_taken); end
      commit();
   endtask

   task automatic test_same_cycle();
      begin_cycle();
      if_pc = 9'h0C; ex_valid = 1'b1; ex_pc = 9'h0C; ex_funct3 = 3'b000; ex_branch = 1'b1;
      ex_imm = 32'h10; src_a = 32'd7; src_b = 32'd7; ex_pred_taken = 1'b0;
      settle();
      checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL rbw_same: got %b want 0", pred_taken); end
      commit();
      begin_cycle();
      if_pc = 9'h0C;
      settle();
      checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL rbw_next: got %b want 1", pred_taken); end
      commit();
   endtask

   task automatic test_random();
      int sel;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         reset     = ($urandom_range(0, 39) != 0);
         sel       = $urandom_range(0, 9);
         ex_valid  = ($urandom_range(0, 4) != 0);
         ex_branch = (sel < 6);
         ex_jal    = (sel == 6);
         ex_jalr   = (sel == 7);
         ex_halt   = 1'b0;
         ex_funct3 = 3'($urandom);
         ex_pc     = PC_W'($urandom);
         ex_imm    = $urandom;
         if_pc     = ($urandom_range(0, 1) != 0) ? ex_pc : PC_W'($urandom);
         src_a     = $urandom;
         src_b     = ($urandom_range(0, 3) == 0) ? src_a : $urandom;
         ex_pred_taken = ($urandom_range(0, 1) != 0) ? model_pred(ex_pc) : 1'($urandom);
         settle();
         checks++; if (pred_taken !== exp_pred) begin errors++; $display("FAIL rnd_pred n=%0d: got %b want %b", n, pred_taken, exp_pred); end
         checks++; if (pc_sel !== exp_pc_sel) begin errors++; $display("FAIL rnd_pc_sel n=%0d: got %b want %b", n, pc_sel, exp_pc_sel); end
         checks++; if (br_pc !== exp_br_pc) begin errors++; $display("FAIL rnd_br_pc n=%0d: got %h want %h", n, br_pc, exp_br_pc); end
         checks++; if (mispredict !== exp_mis) begin errors++; $display("FAIL rnd_mis n=%0d: got %b want %b", n, mispredict, exp_mis); end
         checks++; if (is_jal !== exp_is_jal) begin errors++; $display("FAIL rnd_is_jal n=%0d: got %b want %b", n, is_jal, exp_is_jal); end
         checks++; if (pc_imm !== exp_pc_imm) begin errors++; $display("FAIL rnd_pc_imm n=%0d: got %h want %h", n, pc_imm, exp_pc_imm); end
         checks++; if (pc_four !== exp_pc_four) begin errors++; $display("FAIL rnd_pc_four n=%0d: got %h want %h", n, pc_four, exp_pc_four); end
         commit();
      end
`ifdef BRU_PERF_CNT_EN
      begin_cycle();
      settle();
      checks++; if (perf_branches !== CNT_W'(m_nbr)) begin errors++; $display("FAIL perf_branches: got %0d want %0d", perf_branches, m_nbr); end
      checks++; if (perf_mispredicts !== CNT_W'(m_nmis)) begin errors++; $display("FAIL perf_mispredicts: got %0d want %0d", perf_mispredicts, m_nmis); end
      commit();
`endif
   endtask

   task automatic test_halt();
`ifdef BRU_PERF_CNT_EN
      int nbr_before, nmis_before;
`endif
      // halt carrying a JAL bit as well: halt wins
      begin_cycle();
      ex_valid = 1'b1; ex_halt = 1'b1; ex_jal = 1'b1; ex_pc = 9'h80; ex_imm = 32'h100;
      settle();
      checks++; if (pc_sel !== 1'b1 || br_pc !== 32'h80) begin errors++; $display("FAIL halt_cycle: got sel=%b br=%h want 1/80", pc_sel, br_pc); end
      checks++; if (mispredict !== 1'b0 || halted !== 1'b1) begin errors++; $display("FAIL halt_cycle_flags: got mis=%b halted=%b want 0/1", mispredict, halted); end
      commit();
`ifdef BRU_PERF_CNT_EN
      nbr_before  = m_nbr;
      nmis_before = m_nmis;
`endif
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         reset = 1'b1;
         ex_valid = 1'b1; ex_branch = 1'b1; ex_jal = 1'($urandom); ex_halt = 1'($urandom);
         ex_pc = PC_W'($urandom); if_pc = ex_pc; ex_funct3 = 3'($urandom & 32'h5);
         src_a = $urandom; src_b = src_a; ex_pred_taken = 1'($urandom); ex_imm = $urandom;
         settle();
         checks++; if (pc_sel !== 1'b1) begin errors++; $display("FAIL halted_pc_sel n=%0d: got %b want 1", n, pc_sel); end
         checks++; if (br_pc !== 32'h80) begin errors++; $display("FAIL halted_br_pc n=%0d: got %h want 80", n, br_pc); end
         checks++; if (halted !== 1'b1 || mispredict !== 1'b0) begin errors++; $display("FAIL halted_flags n=%0d: got halted=%b mis=%b want 1/0", n, halted, mispredict); end
         commit();
      end
      for (int i = 0; i < N_ENT; i++) begin
         begin_cycle();
         if_pc = PC_W'(i * 4);
         settle();
         checks++; if (pred_taken !== exp_pred) begin errors++; $display("FAIL halted_bht[%0d]: got %b want %b", i, pred_taken, exp_pred); end
         commit();
      end
`ifdef BRU_PERF_CNT_EN
      begin_cycle();
      settle();
      checks++; if (perf_branches !== CNT_W'(nbr_before) || perf_mispredicts !== CNT_W'(nmis_before)) begin
         errors++; $display("FAIL halted_perf_frozen: got %0d/%0d want %0d/%0d", perf_branches, perf_mispredicts, nbr_before, nmis_before);
      end
      commit();
`endif
      // reset while halted
      @(negedge clk);
      clear_inputs();
      reset = 1'b0;
      settle();
      checks++; if (halted !== 1'b0 || pc_sel !== 1'b0) begin errors++; $display("FAIL halt_reset_hold: got halted=%b sel=%b want 0/0", halted, pc_sel); end
      commit();
      begin_cycle();
      settle();
      checks++; if (halted !== 1'b0 || pc_sel !== 1'b0) begin errors++; $display("FAIL halt_reset_after: got halted=%b sel=%b want 0/0", halted, pc_sel); end
      commit();
   endtask

   initial begin
      reset = 1'b0;
      clear_inputs();
      model_reset();
      test_reset();
      test_beq_loop();
      test_signed_unsigned();
      test_jalr();
      test_same_cycle();
      test_random();
      test_halt();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
